shift_issue_stage: RTL
======================

// Module: shift_issue_stage
// PURPOSE
//  Execute-stage sequencer directly upstream of shift_unit. Accepts decoded RV64 shift
//  ops (SLL/SRL/SRA, imm and W forms) via valid/ready. Drives the combinational
//  shift_unit one pass per cycle: shamt>=32 takes three passes, because the unit's amount
//  port is 5 bits. Presents the 64-bit writeback result downstream via valid/ready.
// PARAMETERS
//  XLEN     64  datapath width; fixed, only 64 supported
//  RD_W     5   destination register tag width
// PORTS
//  clk          in   1     rising-edge clock
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     request valid
//  in_ready     out  1     stage can accept request
//  in_funct3    in   3     001=SLL, 101=SRL/SRA; others illegal
//  in_funct7_5  in   1     instr[30]: 1 selects SRA when funct3=101
//  in_is_word   in   1     1 = *W op (32-bit semantics)
//  in_rs1       in   64    operand to shift
//  in_shamt     in   6     shift amount (rs2[5:0] or imm); bit5 ignored when is_word
//  in_rd        in   RD_W  destination tag, passed through
//  sh_a         out  64    to shift_unit.a
//  sh_b         out  5     to shift_unit.b
//  sh_shift     out  2     to shift_unit.shift: 00=SRL, 01=SRA, 10=SLL
//  sh_result    in   64    from shift_unit.result (combinational)
//  out_valid    out  1     result valid
//  out_ready    in   1     downstream accepts
//  out_result   out  64    final result
//  out_rd       out  RD_W  destination tag
//  out_illegal  out  1     op was illegal; out_result=0
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; out_result=0; out_rd=0; out_illegal=0;
//    sh_a=0; sh_b=0; sh_shift=2'b10. Reset mid-operation discards the op; no output.
//  - FSM: IDLE -> HI1 -> HI2 -> LO -> DONE; IDLE -> LO when shamt[5]=0 or is_word.
//    Illegal ops go IDLE -> DONE directly.
//  - Accept when in_valid & in_ready. On accept: latch rd and mode.
//    acc <= rs1 for 64-bit ops and W-SLL. SRLW: acc <= {32'b0, rs1[31:0]}.
//    SRAW: acc <= {{32{rs1[31]}}, rs1[31:0]}.
//  - HI1/HI2: sh_a=acc, sh_b=16; LO: sh_a=acc, sh_b=shamt[4:0] (0 allowed).
//    Each pass: acc <= sh_result. sh_shift is constant for the whole op.
//  - LO exit: out_result <= is_word ? {{32{sh_result[31]}}, sh_result[31:0]} : sh_result.
//    out_valid <= 1.
//  - Latency accept->out_valid: 2 cycles (1 pass) or 4 cycles (3 passes); illegal: 1.
//  - Illegal: funct3 not in {001,101}, or funct3=001 with funct7_5=1.
//    Result: out_illegal=1, out_result=0.
//  - DONE: out_* held stable while out_valid & !out_ready.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back, no bubble.
//  - DONE & out_ready & !in_valid: go IDLE, out_valid <= 0.
//  - in_ready=0 in HI1/HI2/LO. Request inputs are ignored unless accepted.
// CONFIGURATION
//  SHIFT_ISSUE_STATS_EN defined: adds outputs perf_ops[31:0] and perf_multi[31:0].
//   - perf_ops: +1 per out handshake. perf_multi: +1 per handshake of a 3-pass op.
//   - Both counters wrap at 2^32 and reset to 0.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. SLL rs1=2, shamt=1, out_ready=1 -> out_result=4 two cycles after accept.
//  2. SRA rs1=64'h8000_0000_0000_0000, shamt=40 -> 3 passes; out_result=64'hFFFF_FFFF_FF80_0000 at +4.
//  3. SRAW rs1=64'h0000_0000_8000_0000, shamt=4 -> out_result=64'hFFFF_FFFF_F800_0000.
//     SRLW same inputs -> 64'h0000_0000_0800_0000.
//  4. out_ready=0 for 5 cycles after out_valid -> result/rd stable, in_ready=0.
//     Then out_ready=1 with a new in_valid -> accepted in the same cycle.
//  5. funct3=3'b010 -> out_illegal=1, out_result=0 one cycle after accept.
//     Then rst asserted during HI2 of a 3-pass op -> out_valid stays 0; next op correct.
//  6. With SHIFT_ISSUE_STATS_EN: run tests 1-3 -> perf_ops=4, perf_multi=1.

Source files
------------

// File: rtl/shift_issue_stage_if.sv
// Request/response bundle for shift_issue_stage.
// The slave modport is the stage; master is the upstream/downstream side.
interface shift_issue_stage_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic            in_funct7_5;
  logic            in_is_word;
  logic [63:0]     in_rs1;
  logic [5:0]      in_shamt;
  logic [RD_W-1:0] in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_funct3, in_funct7_5,
    input  in_is_word, in_rs1, in_shamt, in_rd,
    output in_ready,
    output out_valid, out_result, out_rd,
    output out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_funct3, in_funct7_5,
    output in_is_word, in_rs1, in_shamt, in_rd,
    input  in_ready,
    input  out_valid, out_result, out_rd,
    input  out_illegal,
    output out_ready
  );
endinterface

// File: rtl/shift_issue_stage.sv
// RV64 shift sequencer driving a 5-bit-amount shift_unit.
// Optional SHIFT_ISSUE_STATS_EN adds perf_ops/perf_multi counters.
module shift_issue_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  shift_issue_stage_if.slave io,
  output logic [XLEN-1:0] sh_a,
  output logic [4:0]      sh_b,
  output logic [1:0]      sh_shift,
  input  logic [XLEN-1:0] sh_result
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [31:0]     perf_ops,
  output logic [31:0]     perf_multi
`endif
);

  typedef enum logic [2:0] {
    IDLE, HI1, HI2, LO, DONE
  } state_t;

  state_t          state;
  logic [63:0]     acc;
  logic [4:0]      shamt_lo;
  logic            word_q;
  logic [RD_W-1:0] rd_q;

  logic        is_sll;
  logic        is_sr;
  logic        legal;
  logic        take_hi;
  logic        accept;
  logic [1:0]  ld_shift;
  logic [63:0] ld_acc;
  logic [63:0] lo_res;

  assign sh_a = acc;

  assign io.in_ready =
    (state == IDLE) |
    ((state == DONE) & io.out_ready);

  assign accept = io.in_valid & io.in_ready;

  always_comb begin
    is_sll  = (io.in_funct3 == 3'b001) &
              !io.in_funct7_5;
    is_sr   = (io.in_funct3 == 3'b101);
    legal   = is_sll | is_sr;
    take_hi = io.in_shamt[5] & !io.in_is_word;
    ld_shift = 2'b00;
    unique case (1'b1)
      is_sll:                 ld_shift = 2'b10;
      is_sr & io.in_funct7_5: ld_shift = 2'b01;
      default:                ld_shift = 2'b00;
    endcase
    // W right shifts pre-extend so the low word shifts in correct bits
    if (!io.in_is_word || is_sll)
      ld_acc = io.in_rs1;
    else if (io.in_funct7_5)
      ld_acc = {{32{io.in_rs1[31]}},
                io.in_rs1[31:0]};
    else
      ld_acc = {32'b0, io.in_rs1[31:0]};
    lo_res = word_q ?
      {{32{sh_result[31]}}, sh_result[31:0]} :
      sh_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      sh_b           <= '0;
      sh_shift       <= 2'b10;
      shamt_lo       <= '0;
      word_q         <= 1'b0;
      rd_q           <= '0;
      io.out_valid   <= 1'b0;
      io.out_result  <= '0;
      io.out_rd      <= '0;
      io.out_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        HI1: begin
          acc   <= sh_result;
          state <= HI2;
        end
        HI2: begin
          acc   <= sh_result;
          sh_b  <= shamt_lo;
          state <= LO;
        end
        LO: begin
          acc            <= sh_result;
          io.out_result  <= lo_res;
          io.out_rd      <= rd_q;
          io.out_illegal <= 1'b0;
          io.out_valid   <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new accept overrides the DONE drain above
      if (accept) begin
        rd_q     <= io.in_rd;
        word_q   <= io.in_is_word;
        shamt_lo <= io.in_shamt[4:0];
        sh_shift <= ld_shift;
        acc      <= ld_acc;
        if (!legal) begin
          io.out_valid   <= 1'b1;
          io.out_illegal <= 1'b1;
          io.out_result  <= '0;
          io.out_rd      <= io.in_rd;
          state          <= DONE;
        end else if (take_hi) begin
          sh_b  <= 5'd16;
          state <= HI1;
        end else begin
          sh_b  <= io.in_shamt[4:0];
          state <= LO;
        end
      end
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  logic multi_q;
  logic multi_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_q    <= 1'b0;
      multi_out  <= 1'b0;
      perf_ops   <= '0;
      perf_multi <= '0;
    end else begin
      if (accept)
        multi_q <= legal & take_hi;
      if (accept && !legal)
        multi_out <= 1'b0;
      else if (state == LO)
        multi_out <= multi_q;
      if (io.out_valid && io.out_ready) begin
        perf_ops <= perf_ops + 32'd1;
        if (multi_out)
          perf_multi <= perf_multi + 32'd1;
      end
    end
  end
`endif

endmodule
